// File: rtl/sub_pkg.sv
// Shared constants and state encoding for the sliced 72-bit subtractor.
package sub_pkg;

  localparam int SLICE_W = 24;
  localparam int NSLICE  = 3;
  localparam int W       = SLICE_W * NSLICE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SL0  = 3'd1,
    SL1  = 3'd2,
    SL2  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/sub24_slice.sv
// One combinational subtract slice: d = a - b - bin, bout set when the slice borrows.
module sub24_slice
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               bin_i,
  output logic [SLICE_W-1:0] d_o,
  output logic               bout_o
);

  logic [SLICE_W:0] sum;

  // a + ~b + ~bin: the carry out of this sum is the inverse of the borrow out.
  always_comb begin
    sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{SLICE_W{1'b0}}, ~bin_i};
    d_o    = sum[SLICE_W-1:0];
    bout_o = ~sum[SLICE_W];
  end

endmodule

// File: rtl/sub72_seq.sv
// Multi-cycle 72-bit subtractor: one 24-bit slice per clock, LSB first, borrow carried
// between slices in a register, behind valid/ready operand and result ports.
module sub72_seq
  import sub_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W:1]   A,
  input  logic [W:1]   B,
  input  logic         b0,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W:1]   D,
  output logic         b72,
  output logic         zx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // The producer holds its payload stable while valid is high and ready is low; this
  // block holds out_valid/D/b72/zx in DONE until out_ready, and takes operands only
  // when in_ready is high (IDLE, or DONE while the result is being consumed).

  state_e           state_q;
  logic [W:1]       a_q;
  logic [W:1]       b_q;
  logic             borrow_q;
  logic [W:1]       d_q;
  logic             b72_q;
  logic             zx_q;
  logic             out_valid_q;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] sl_d;
  logic               sl_bout;

  always_comb begin
    a_sl = a_q[SLICE_W:1];
    b_sl = b_q[SLICE_W:1];
    case (state_q)
      SL1: begin
        a_sl = a_q[2*SLICE_W:SLICE_W+1];
        b_sl = b_q[2*SLICE_W:SLICE_W+1];
      end
      SL2: begin
        a_sl = a_q[W:2*SLICE_W+1];
        b_sl = b_q[W:2*SLICE_W+1];
      end
      default: ;
    endcase
  end

  sub24_slice u_slice (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .bin_i  (borrow_q),
    .d_o    (sl_d),
    .bout_o (sl_bout)
  );

  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      d_q         <= '0;
      b72_q       <= 1'b0;
      zx_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= b0;
            state_q  <= SL0;
          end
        end
        SL0: begin
          d_q[SLICE_W:1] <= sl_d;
          borrow_q       <= sl_bout;
          state_q        <= SL1;
        end
        SL1: begin
          d_q[2*SLICE_W:SLICE_W+1] <= sl_d;
          borrow_q                 <= sl_bout;
          state_q                  <= SL2;
        end
        SL2: begin
          d_q[W:2*SLICE_W+1] <= sl_d;
          borrow_q           <= sl_bout;
          b72_q              <= sl_bout;
          // Lower slices are already final, so the zero flag is known as the top slice lands.
          zx_q               <= (sl_d == '0) && (d_q[2*SLICE_W:1] == '0);
          out_valid_q        <= 1'b1;
          state_q            <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              a_q      <= A;
              b_q      <= B;
              borrow_q <= b0;
              state_q  <= SL0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign D           = d_q;
  assign b72         = b72_q;
  assign zx          = zx_q;
  assign out_valid   = out_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sub72_seq.sv
// Bench for sub72_seq: directed corner cases, stall/reset scenarios and random traffic
// checked against an arithmetic reference A - B - b0.
module tb_sub72_seq;
  import sub_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [W:1]   a_in;
  logic [W:1]   b_in;
  logic         b0_in;
  logic         in_valid;
  logic         in_ready;
  logic [W:1]   d_out;
  logic         b72_out;
  logic         zx_out;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   dbg_state;

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  bit           stall_mode = 0;
  bit           force_ready = 1;

  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  sub72_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (a_in),
    .B           (b_in),
    .b0          (b0_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .D           (d_out),
    .b72         (b72_out),
    .zx          (zx_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // ---------------- reference model and check helper ----------------
  function automatic logic [W+1:0] model(input logic [W:1] a, input logic [W:1] b,
                                         input logic bi);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    return {(r[W-1:0] == '0), r[W], r[W-1:0]};
  endfunction

  task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_mode) out_ready = ($urandom_range(0, 3) != 0);
      else            out_ready = force_ready;
    end
  end

  task automatic send(input logic [W:1] a, input logic [W:1] b, input logic bi);
    int waited;
    waited = 0;
    @(negedge clk);
    a_in = a; b_in = b; b0_in = bi; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed low for %0d cycles", waited);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    exp_q.push_back(model(a, b, bi));
    acc_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  function automatic logic [W:1] rand72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit           prev_valid;
    bit           prev_hold;
    logic [W+1:0] held;
    logic [W+1:0] got;
    logic [W+1:0] exp;
    int           acc;
    prev_valid = 0; prev_hold = 0; held = '0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        prev_valid = 0; prev_hold = 0;
        continue;
      end
      got = {zx_out, b72_out, d_out};
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: out_valid with nothing outstanding, D=%h", d_out);
        end else begin
          acc = acc_q.pop_front();
          chk("latency", W'(cyc), W'(acc + 3));
        end
      end
      if (out_valid && prev_hold) chk("hold_stable", got, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_result: D=%h with empty expected queue", d_out);
        end else begin
          exp = exp_q.pop_front();
          chk("result", got, exp);
        end
      end
      prev_valid = out_valid;
      prev_hold  = out_valid && !out_ready;
      held       = got;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", W'(exp_q.size()), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W:1] ones;
    ones = '1;
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; b0_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_D", W'(d_out), '0);
    chk("rst_b72_zx", W'({b72_out, zx_out}), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_state", W'(dbg_state), W'(IDLE));

    // Directed corner cases
    send('0, '0, 1'b0);
    send('0, W'(1), 1'b0);
    send(W'(72'h1_000000), W'(1), 1'b0);
    send(W'(72'h1_000000_000000), W'(1), 1'b0);
    send(W'(72'h123456_789ABC_DEF012), W'(72'h123456_789ABC_DEF012), 1'b1);
    send(ones, ones, 1'b0);
    send(ones, '0, 1'b1);
    drain();
    chk("dir_max_minus_zero", model(ones, '0, 1'b1), {1'b0, 1'b0, ones - W'(1)});

    // Stall in DONE for five cycles, then consume and accept on the same edge
    force_ready = 1'b0;
    @(negedge clk);
    send(W'(72'hABCDEF_012345_6789AB), W'(72'h0000FF_00FF00_FF00FF), 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
    end
    chk("stall_reach_done", W'(out_valid), W'(1));
    repeat (5) begin
      @(negedge clk); #3;
      chk("stall_in_ready", W'(in_ready), '0);
      chk("stall_state", W'(dbg_state), W'(DONE));
    end
    force_ready = 1'b1;
    send(W'(72'h000000_000001_000000), W'(72'h000000_000000_000002), 1'b1);
    chk("b2b_state_sl0", W'(dbg_state), W'(SL0));
    drain();

    // Reset in the middle of an operation
    send(W'(72'h555555_555555_555555), W'(72'h111111_111111_111111), 1'b0);
    @(posedge clk); #1;
    chk("pre_abort_state", W'(dbg_state), W'(SL1));
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", W'(out_valid), '0);
    chk("abort_D", W'(d_out), '0);
    chk("abort_in_ready", W'(in_ready), W'(1));
    chk("abort_state", W'(dbg_state), W'(IDLE));
    exp_q.delete();
    acc_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_result", W'(out_valid), '0);
    send(W'(72'h0F0F0F_0F0F0F_0F0F0F), W'(72'hF0F0F0_F0F0F0_F0F0F0), 1'b1);
    drain();

    // Random traffic with random consumer stalls
    stall_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [W:1] ra, rb;
      ra = rand72();
      rb = rand72();
      case ($urandom_range(0, 4))
        0: rb = ra;
        1: begin ra = W'($urandom_range(0, 3)); rb = W'($urandom_range(0, 3)); end
        2: begin ra = ra & W'(72'hFFFFFF_000000_000000); rb = W'($urandom_range(0, 1)); end
        default: ;
      endcase
      send(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    stall_mode = 0;
    force_ready = 1'b1;
    drain();
    repeat (4) @(negedge clk);
    chk("final_acc_empty", W'(acc_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
